// File: rtl/demux_8_bit_buf.sv
// -----------------------------------------------------------------------------
// demux_8_bit_buf
//
// Buffered 1-to-2 byte demultiplexer. A byte presented on the valid/ready input
// stream is steered by in_sel into one of two independent FIFOs. Each FIFO is
// drained by its own valid/ready output port, so the two consumers can apply
// backpressure independently of each other.
//
// Ports:
//   clk, rst_n          clock (rising edge) / asynchronous active-low reset
//   in_data, in_sel     byte to route; in_sel=1 -> port a, in_sel=0 -> port b
//   in_valid, in_ready  input handshake; in_ready reflects the selected FIFO only
//   a_data, a_valid     head of FIFO a / FIFO a non-empty
//   a_ready             consumer a takes the head
//   b_data, b_valid     head of FIFO b / FIFO b non-empty
//   b_ready             consumer b takes the head
//   a_count, b_count    FIFO occupancy, 0..DEPTH
//
// Optional build macro DEMUX_8_BIT_BUF_STATS_EN adds a_total / b_total, 16-bit
// wrapping counts of bytes pushed into each FIFO.
// -----------------------------------------------------------------------------
module demux_8_bit_buf #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2,
    localparam int CW   = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_sel,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] a_data,
    output logic             a_valid,
    input  logic             a_ready,
    output logic [WIDTH-1:0] b_data,
    output logic             b_valid,
    input  logic             b_ready,
    output logic [CW-1:0]    a_count,
    output logic [CW-1:0]    b_count
`ifdef DEMUX_8_BIT_BUF_STATS_EN
    ,
    output logic [15:0]      a_total,
    output logic [15:0]      b_total
`endif
);

    // DEPTH is a power of two, so pointers of this width wrap modulo DEPTH
    // on their own.
    localparam int AW = $clog2(DEPTH);
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    // Index 0 is FIFO a, index 1 is FIFO b.
    logic [1:0]       push;
    logic [1:0]       pop;
    logic [1:0]       rdy;
    logic [WIDTH-1:0] head [2];
    logic [CW-1:0]    cnt  [2];

    // Readiness depends only on the selected FIFO's occupancy, never on the
    // consumers, so there is no combinational path from a_ready/b_ready.
    assign in_ready = in_sel ? (cnt[0] != FULL) : (cnt[1] != FULL);

    assign push[0] = in_valid && in_ready &&  in_sel;
    assign push[1] = in_valid && in_ready && !in_sel;
    assign rdy     = {b_ready, a_ready};

    for (genvar p = 0; p < 2; p++) begin : g_fifo
        logic [WIDTH-1:0] mem [DEPTH];
        logic [AW-1:0]    wr_ptr;
        logic [AW-1:0]    rd_ptr;
        logic [CW-1:0]    count;

        assign pop[p]  = (count != '0) && rdy[p];
        assign head[p] = mem[rd_ptr];
        assign cnt[p]  = count;

        // NOTE: the storage is tiny and the head is visible on the output port,
        // so it is cleared on reset to give a defined 0 on x_data; larger
        // buffers would normally leave memory unreset.
        // NOTE: all state here uses non-blocking assignments so every register
        // samples pre-edge values, keeping push and pop in the same cycle
        // independent of statement order.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                for (int i = 0; i < DEPTH; i++) begin
                    mem[i] <= '0;
                end
                wr_ptr <= '0;
                rd_ptr <= '0;
                count  <= '0;
            end else begin
                if (push[p]) begin
                    mem[wr_ptr] <= in_data;
                    wr_ptr      <= wr_ptr + 1'b1;
                end
                if (pop[p]) begin
                    rd_ptr <= rd_ptr + 1'b1;
                end
                // Simultaneous push and pop leaves the occupancy unchanged.
                case ({push[p], pop[p]})
                    2'b10:   count <= count + 1'b1;
                    2'b01:   count <= count - 1'b1;
                    default: count <= count;
                endcase
            end
        end
    end

    assign a_data  = head[0];
    assign b_data  = head[1];
    assign a_count = cnt[0];
    assign b_count = cnt[1];
    assign a_valid = (cnt[0] != '0);
    assign b_valid = (cnt[1] != '0);

`ifdef DEMUX_8_BIT_BUF_STATS_EN
    // Push counters; natural 16-bit overflow gives the FFFF -> 0 wrap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_total <= '0;
            b_total <= '0;
        end else begin
            if (push[0]) a_total <= a_total + 16'd1;
            if (push[1]) b_total <= b_total + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_demux_8_bit_buf.sv
// -----------------------------------------------------------------------------
// tb_demux_8_bit_buf
//
// Directed bench for demux_8_bit_buf (DEPTH=2). Inputs are driven 1 time unit
// after each rising edge and outputs are sampled there, away from the edge.
// -----------------------------------------------------------------------------
module tb_demux_8_bit_buf;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] in_data;
    logic       in_sel;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] a_data;
    logic       a_valid;
    logic       a_ready;
    logic [7:0] b_data;
    logic       b_valid;
    logic       b_ready;
    logic [1:0] a_count;
    logic [1:0] b_count;
`ifdef DEMUX_8_BIT_BUF_STATS_EN
    logic [15:0] a_total;
    logic [15:0] b_total;
`endif

    int total = 0;
    int bad   = 0;

    demux_8_bit_buf dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_data  (in_data),
        .in_sel   (in_sel),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .a_data   (a_data),
        .a_valid  (a_valid),
        .a_ready  (a_ready),
        .b_data   (b_data),
        .b_valid  (b_valid),
        .b_ready  (b_ready),
        .a_count  (a_count),
        .b_count  (b_count)
`ifdef DEMUX_8_BIT_BUF_STATS_EN
        ,
        .a_total  (a_total),
        .b_total  (b_total)
`endif
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [15:0] observed,
                         input logic [15:0] expected);
        total++;
        assert (observed === expected) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic push(input logic sel, input logic [7:0] data);
        in_sel   = sel;
        in_data  = data;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
    endtask

    initial begin
        int sent;
        int rx;
        int cyc;
        logic do_push;
        logic do_pop;

        rst_n    = 1'b0;
        in_data  = 8'h00;
        in_sel   = 1'b0;
        in_valid = 1'b0;
        a_ready  = 1'b0;
        b_ready  = 1'b0;

        // Reset state
        #2;
        check("rst_a_valid", a_valid, 0);
        check("rst_b_valid", b_valid, 0);
        check("rst_a_count", a_count, 0);
        check("rst_b_count", b_count, 0);
        check("rst_a_data",  a_data,  8'h00);
        check("rst_b_data",  b_data,  8'h00);
        check("rst_in_ready", in_ready, 1);
        tick();
        rst_n = 1'b1;

        // Routing
        push(1'b1, 8'hA5);
        push(1'b0, 8'h3C);
        check("route_a_data",  a_data,  8'hA5);
        check("route_a_count", a_count, 1);
        check("route_a_valid", a_valid, 1);
        check("route_b_data",  b_data,  8'h3C);
        check("route_b_count", b_count, 1);
        check("route_b_valid", b_valid, 1);

        // Drain both
        a_ready = 1'b1;
        b_ready = 1'b1;
        tick();
        a_ready = 1'b0;
        b_ready = 1'b0;
        check("drain_a_count", a_count, 0);
        check("drain_b_valid", b_valid, 0);

        // Full and backpressure
        push(1'b1, 8'h01);
        push(1'b1, 8'h02);
        check("full_a_count", a_count, 2);
        check("full_a_data",  a_data,  8'h01);
        in_sel = 1'b1;
        #1;
        check("full_ready_sel_a", in_ready, 0);
        in_sel = 1'b0;
        #1;
        check("full_ready_sel_b", in_ready, 1);
        push(1'b1, 8'h99);  // stalled: must not be written
        check("stall_a_count", a_count, 2);
        check("stall_a_data",  a_data,  8'h01);
        push(1'b0, 8'h77);
        check("other_b_count", b_count, 1);
        check("other_b_data",  b_data,  8'h77);
        check("other_a_count", a_count, 2);

        // Drain in order
        a_ready = 1'b1;
        tick();
        check("order_a_data1", a_data,  8'h02);
        check("order_a_count", a_count, 1);
        tick();
        check("order_a_empty", a_valid, 0);
        a_ready = 1'b0;
        b_ready = 1'b1;
        tick();
        b_ready = 1'b0;
        check("drain_b_count", b_count, 0);

        // Simultaneous push/pop
        push(1'b1, 8'h11);
        check("simul_pre_count", a_count, 1);
        check("simul_pre_data",  a_data,  8'h11);
        a_ready = 1'b1;
        push(1'b1, 8'h22);
        a_ready = 1'b0;
        check("simul_count", a_count, 1);
        check("simul_data",  a_data,  8'h22);
        a_ready = 1'b1;
        tick();
        a_ready = 1'b0;
        check("simul_drain", a_count, 0);

        // Wrap and ordering: 00..09 into a with a_ready toggling
        sent = 0;
        rx   = 0;
        cyc  = 0;
        in_sel = 1'b1;
        while (rx < 10 && cyc < 60) begin
            a_ready  = cyc[0];
            in_valid = (sent < 10);
            in_data  = 8'(sent);
            #1;
            do_push = in_valid && in_ready;
            do_pop  = a_valid && a_ready;
            if (do_pop) begin
                check("wrap_data", a_data, 16'(rx));
                rx++;
            end
            if (do_push) sent++;
            tick();
            check("wrap_count_le2", {15'd0, a_count <= 2'd2}, 1);
            cyc++;
        end
        in_valid = 1'b0;
        a_ready  = 1'b0;
        check("wrap_received", 16'(rx), 10);
        check("wrap_empty", a_count, 0);

        // Asynchronous reset mid-operation with both FIFOs full
        push(1'b1, 8'hC1);
        push(1'b1, 8'hC2);
        push(1'b0, 8'hD1);
        push(1'b0, 8'hD2);
        check("pre_rst_a_count", a_count, 2);
        check("pre_rst_b_count", b_count, 2);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_a_valid", a_valid, 0);
        check("arst_b_valid", b_valid, 0);
        check("arst_a_count", a_count, 0);
        check("arst_b_count", b_count, 0);
        check("arst_a_data",  a_data,  8'h00);
        check("arst_b_data",  b_data,  8'h00);
        check("arst_in_ready", in_ready, 1);
        tick();
        rst_n = 1'b1;

`ifdef DEMUX_8_BIT_BUF_STATS_EN
        check("stats_a_rst", a_total, 0);
        check("stats_b_rst", b_total, 0);
        b_ready  = 1'b1;
        in_sel   = 1'b0;
        in_data  = 8'h5A;
        in_valid = 1'b1;
        for (int i = 0; i < 65537; i++) begin
            tick();
        end
        in_valid = 1'b0;
        b_ready  = 1'b0;
        check("stats_b_wrap", b_total, 1);
        check("stats_a_zero", a_total, 0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
